// File: rtl/l0_pool_reader.sv
// 2x2/stride-2 max-pool reader over two layer-0 channel RAMs, paced by the layer-0 write count.
// Latency: 5 cycles from RD entry to out_vld; holds the pooled pixel and stops reading while !out_rdy.
module l0_pool_reader #(
    parameter int W  = 28,
    parameter int H  = 28,
    parameter int DW = 18,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tx_done,
    input  logic [AW-1:0] wr_cnt,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_dout_0,
    input  logic [DW-1:0] ram_dout_1,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] pool_0,
    output logic [DW-1:0] pool_1,
    output logic [AW-1:0] out_idx,
    output logic          frame_done
);

    localparam int PW    = W / 2;
    localparam int NPOOL = PW * (H / 2);

    localparam logic [AW-1:0] ONE_A    = AW'(1);
    localparam logic [AW-1:0] TWO_A    = AW'(2);
    localparam logic [AW-1:0] ROW_A    = AW'(W);
    localparam logic [AW-1:0] LAST_IDX = AW'(NPOOL - 1);
    localparam logic [AW-1:0] LAST_COL = AW'(PW - 1);
    localparam logic [AW:0]   LEAD     = (AW + 1)'(W + 2);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_RD,
        ST_CAP,
        ST_OUT,
        ST_DONE
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] base;
    logic [AW-1:0] col;
    logic [1:0]    k;
    logic [DW-1:0] max_0, max_1;
    logic [AW-1:0] next_addr;
    logic          wr_ok;
    logic          last_win;
    logic          hs;

    function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (b > a) ? b : a;
    endfunction

    // The window's last pixel sits at base+W+1, so all four exist once wr_cnt > base+W+1.
    assign wr_ok    = ({1'b0, wr_cnt} >= ({1'b0, base} + LEAD));
    assign last_win = (out_idx == LAST_IDX);
    assign out_vld  = (state == ST_OUT);
    assign hs       = out_vld && out_rdy;
    assign pool_0   = max_0;
    assign pool_1   = max_1;

    always_comb begin
        next_addr = base + ROW_A + ONE_A;
        case (k)
            2'd0:    next_addr = base + ONE_A;
            2'd1:    next_addr = base + ROW_A;
            default: next_addr = base + ROW_A + ONE_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_WAIT: if (wr_ok) state_n = ST_RD;
            ST_RD:   if (k == 2'd3) state_n = ST_CAP;
            ST_CAP:  state_n = ST_OUT;
            ST_OUT:  if (hs) state_n = last_win ? ST_DONE : ST_WAIT;
            ST_DONE: state_n = ST_DONE;
            default: state_n = ST_WAIT;
        endcase
        if (tx_done) state_n = ST_WAIT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base       <= '0;
            col        <= '0;
            k          <= '0;
            max_0      <= '0;
            max_1      <= '0;
            out_idx    <= '0;
            ram_addr   <= '0;
            frame_done <= 1'b0;
        end else if (tx_done) begin
            base       <= '0;
            col        <= '0;
            k          <= '0;
            max_0      <= '0;
            max_1      <= '0;
            out_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_WAIT: begin
                    if (wr_ok) begin
                        ram_addr <= base;
                        k        <= '0;
                    end
                end
                ST_RD: begin
                    k <= k + 2'd1;
                    if (k != 2'd3) ram_addr <= next_addr;
                    // RAM data lags the address by one cycle: k==1 carries pixel 0.
                    if (k == 2'd1) begin
                        max_0 <= ram_dout_0;
                        max_1 <= ram_dout_1;
                    end else if (k != 2'd0) begin
                        max_0 <= umax(max_0, ram_dout_0);
                        max_1 <= umax(max_1, ram_dout_1);
                    end
                end
                ST_CAP: begin
                    max_0 <= umax(max_0, ram_dout_0);
                    max_1 <= umax(max_1, ram_dout_1);
                end
                ST_OUT: begin
                    if (hs) begin
                        out_idx <= out_idx + ONE_A;
                        if (col == LAST_COL) begin
                            col  <= '0;
                            base <= base + ROW_A + TWO_A;
                        end else begin
                            col  <= col + ONE_A;
                            base <= base + TWO_A;
                        end
                        if (last_win) frame_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l0_pool_reader.sv
// Randomized bench for l0_pool_reader against a window-max reference over behavioural channel RAMs.
module tb_l0_pool_reader;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int DW   = 18;
    localparam int AW   = 10;
    localparam int PW   = W / 2;
    localparam int NP   = PW * (H / 2);
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tx_done;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout_0;
    logic [DW-1:0] ram_dout_1;
    logic          out_vld;
    logic          out_rdy;
    logic [DW-1:0] pool_0;
    logic [DW-1:0] pool_1;
    logic [AW-1:0] out_idx;
    logic          frame_done;

    logic [DW-1:0] mem0 [NPIX];
    logic [DW-1:0] mem1 [NPIX];

    int checks = 0;
    int passes = 0;

    l0_pool_reader #(.W(W), .H(H), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_done    (tx_done),
        .wr_cnt     (wr_cnt),
        .ram_addr   (ram_addr),
        .ram_dout_0 (ram_dout_0),
        .ram_dout_1 (ram_dout_1),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .pool_0     (pool_0),
        .pool_1     (pool_1),
        .out_idx    (out_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_dout_0 <= (int'(ram_addr) < NPIX) ? mem0[ram_addr] : '0;
        ram_dout_1 <= (int'(ram_addr) < NPIX) ? mem1[ram_addr] : '0;
    end

    function automatic logic [DW-1:0] ref_pool(input int ch, input int idx);
        int            r, c, b;
        int            offs [4];
        logic [DW-1:0] m, v;
        r = idx / PW;
        c = idx % PW;
        b = 2 * r * W + 2 * c;
        offs = '{0, 1, W, W + 1};
        m = '0;
        for (int i = 0; i < 4; i++) begin
            v = (ch == 0) ? mem0[b + offs[i]] : mem1[b + offs[i]];
            if (v > m) m = v;
        end
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_frame();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic fill_addr();
        for (int i = 0; i < NPIX; i++) begin
            mem0[i] = DW'(i);
            mem1[i] = DW'(i);
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NPIX; i++) begin
            mem0[i] = DW'($urandom);
            mem1[i] = DW'($urandom);
        end
    endtask

    task automatic test_reset();
        logic [AW-1:0] exp_addr [4];
        rst_n = 1'b0; tx_done = 1'b0; wr_cnt = '0; out_rdy = 1'b0;
        fill_addr();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_vld !== 1'b0) $display("FAIL rst_vld: got %b want 0", out_vld); else passes++;
        checks++; if (ram_addr !== '0) $display("FAIL rst_addr: got %0d want 0", ram_addr); else passes++;
        checks++; if (out_idx !== '0) $display("FAIL rst_idx: got %0d want 0", out_idx); else passes++;
        checks++; if (frame_done !== 1'b0) $display("FAIL rst_fd: got %b want 0", frame_done); else passes++;
        checks++; if (pool_0 !== '0 || pool_1 !== '0) $display("FAIL rst_pool: got %0h/%0h want 0/0", pool_0, pool_1); else passes++;
        rst_n = 1'b1;
        step();
        wr_cnt = AW'(NPIX);
        step();
        step();
        // now mid-RD with ram_addr already moved off 0
        rst_n = 1'b0;
        #1;
        checks++; if (ram_addr !== '0) $display("FAIL midrd_addr: got %0d want 0", ram_addr); else passes++;
        checks++; if (out_vld !== 1'b0 || out_idx !== '0 || frame_done !== 1'b0) $display("FAIL midrd_out: vld %b idx %0d fd %b want 0", out_vld, out_idx, frame_done); else passes++;
        wr_cnt = '0;
        #3 rst_n = 1'b1;
        step();
        wr_cnt = AW'(29);
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if (ram_addr !== '0 || out_vld !== 1'b0) $display("FAIL gate29: cyc %0d addr %0d vld %b want 0/0", i, ram_addr, out_vld); else passes++;
        end
        wr_cnt = AW'(30);
        exp_addr = '{AW'(0), AW'(1), AW'(W), AW'(W + 1)};
        for (int e = 1; e <= 6; e++) begin
            step();
            checks++; if (ram_addr !== exp_addr[(e > 4) ? 3 : e - 1]) $display("FAIL gate_addr: edge %0d got %0d want %0d", e, ram_addr, exp_addr[(e > 4) ? 3 : e - 1]); else passes++;
            checks++; if (out_vld !== (e == 6)) $display("FAIL gate_lat: edge %0d vld %b want %b", e, out_vld, (e == 6)); else passes++;
        end
        checks++; if (pool_0 !== DW'(29) || pool_1 !== DW'(29)) $display("FAIL gate_pool: got %0d/%0d want 29/29", pool_0, pool_1); else passes++;
        checks++; if (out_idx !== '0) $display("FAIL gate_idx: got %0d want 0", out_idx); else passes++;
        wr_cnt = '0;
        clear_frame();
    endtask

    task automatic run_frame(input bit rand_data, input bit rand_rdy, input bit pace);
        int            n, post, cyc, last_hs, fds, a, bb;
        bit            fd_exp;
        logic [AW-1:0] prev_addr;
        logic [DW-1:0] got0 [NP];
        if (rand_data) fill_rand(); else fill_addr();
        wr_cnt = '0; out_rdy = 1'b0;
        clear_frame();
        wr_cnt = pace ? '0 : AW'(NPIX);
        n = 0; post = 0; cyc = 0; last_hs = 0; fds = 0; fd_exp = 1'b0;
        prev_addr = ram_addr;
        while (cyc < 8000 && (n < NP || post < 10)) begin
            out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            checks++; if (frame_done !== fd_exp) $display("FAIL fd_pulse: cyc %0d got %b want %b", cyc, frame_done, fd_exp); else passes++;
            if (frame_done === 1'b1) fds++;
            fd_exp = 1'b0;
            if (pace && ram_addr !== prev_addr) begin
                a = int'(ram_addr);
                bb = (a / (2 * W)) * 2 * W + ((a % W) / 2) * 2;
                checks++; if (int'(wr_cnt) < bb + W + 2) $display("FAIL early_read: addr %0d wr_cnt %0d need %0d", a, wr_cnt, bb + W + 2); else passes++;
            end
            prev_addr = ram_addr;
            if (out_vld === 1'b1) begin
                checks++;
                if (n >= NP) begin
                    $display("FAIL extra_out: got idx %0d after %0d outputs", out_idx, NP);
                end else begin
                    passes++;
                    checks++; if (pool_0 !== ref_pool(0, n)) $display("FAIL pool0: n %0d got %0h want %0h", n, pool_0, ref_pool(0, n)); else passes++;
                    checks++; if (pool_1 !== ref_pool(1, n)) $display("FAIL pool1: n %0d got %0h want %0h", n, pool_1, ref_pool(1, n)); else passes++;
                    checks++; if (out_idx !== AW'(n)) $display("FAIL idx: got %0d want %0d", out_idx, n); else passes++;
                    got0[n] = pool_0;
                    if (out_rdy) begin
                        if (!rand_rdy && !pace && n > 0) begin
                            checks++; if (cyc - last_hs != 7) $display("FAIL rate: got %0d cycles want 7", cyc - last_hs); else passes++;
                        end
                        last_hs = cyc;
                        n++;
                        if (n == NP) fd_exp = 1'b1;
                    end
                end
            end
            if (n >= NP) post++;
            if (pace && int'(wr_cnt) < NPIX && $urandom_range(0, 1) == 1) wr_cnt = wr_cnt + AW'(1);
            step();
            cyc++;
        end
        checks++; if (n != NP) $display("FAIL out_count: got %0d want %0d", n, NP); else passes++;
        checks++; if (fds != 1) $display("FAIL fd_count: got %0d want 1", fds); else passes++;
        if (!rand_data && n == NP) begin
            checks++; if (got0[0] !== DW'(29)) $display("FAIL idx0: got %0d want 29", got0[0]); else passes++;
            checks++; if (got0[1] !== DW'(31)) $display("FAIL idx1: got %0d want 31", got0[1]); else passes++;
            checks++; if (got0[13] !== DW'(55)) $display("FAIL idx13: got %0d want 55", got0[13]); else passes++;
            checks++; if (got0[14] !== DW'(85)) $display("FAIL idx14: got %0d want 85", got0[14]); else passes++;
            checks++; if (got0[195] !== DW'(783)) $display("FAIL idx195: got %0d want 783", got0[195]); else passes++;
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] p0, p1;
        logic [AW-1:0] idx, addr;
        int            t;
        fill_rand();
        wr_cnt = '0; out_rdy = 1'b0;
        clear_frame();
        wr_cnt = AW'(NPIX);
        t = 0;
        while (out_vld !== 1'b1 && t < 20) begin step(); t++; end
        checks++; if (out_vld !== 1'b1) $display("FAIL bp_wait: got vld %b want 1", out_vld); else passes++;
        p0 = pool_0; p1 = pool_1; idx = out_idx; addr = ram_addr;
        checks++; if (p0 !== ref_pool(0, 0) || p1 !== ref_pool(1, 0)) $display("FAIL bp_pool: got %0h/%0h want %0h/%0h", p0, p1, ref_pool(0, 0), ref_pool(1, 0)); else passes++;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (out_vld !== 1'b1 || pool_0 !== p0 || pool_1 !== p1 || out_idx !== idx || ram_addr !== addr)
                $display("FAIL bp_hold: cyc %0d vld %b p %0h/%0h idx %0d addr %0d want 1 %0h/%0h %0d %0d",
                         i, out_vld, pool_0, pool_1, out_idx, ram_addr, p0, p1, idx, addr);
            else passes++;
        end
        out_rdy = 1'b1;
        step();
        checks++; if (out_vld !== 1'b0) $display("FAIL bp_release: got vld %b want 0", out_vld); else passes++;
        step();
        checks++; if (ram_addr !== AW'(2)) $display("FAIL bp_next_base: got %0d want 2", ram_addr); else passes++;
        t = 0;
        while (out_vld !== 1'b1 && t < 20) begin step(); t++; end
        checks++; if (out_idx !== AW'(1) || pool_0 !== ref_pool(0, 1)) $display("FAIL bp_second: idx %0d pool %0h want 1 %0h", out_idx, pool_0, ref_pool(0, 1)); else passes++;
    endtask

    task automatic test_max();
        int t;
        fill_rand();
        mem0[0] = DW'(5); mem0[1] = DW'(9); mem0[W] = 18'h3FFFF; mem0[W + 1] = DW'(1);
        mem1[0] = DW'(7); mem1[1] = '0;     mem1[W] = '0;        mem1[W + 1] = '0;
        wr_cnt = '0; out_rdy = 1'b0;
        clear_frame();
        wr_cnt = AW'(NPIX);
        t = 0;
        while (out_vld !== 1'b1 && t < 20) begin step(); t++; end
        checks++; if (pool_0 !== 18'h3FFFF) $display("FAIL max_ch0: got %0h want 3ffff", pool_0); else passes++;
        checks++; if (pool_1 !== DW'(7)) $display("FAIL max_ch1: got %0h want 7", pool_1); else passes++;
    endtask

    task automatic test_tx_done();
        int t, fds;
        fill_addr();
        wr_cnt = '0; out_rdy = 1'b0;
        clear_frame();
        wr_cnt = AW'(NPIX);
        out_rdy = 1'b1;
        t = 0;
        while (!(out_vld === 1'b1 && out_idx == AW'(40)) && t < 2000) begin step(); t++; end
        checks++; if (out_idx !== AW'(40) || out_vld !== 1'b1) $display("FAIL txd_reach: idx %0d vld %b want 40 1", out_idx, out_vld); else passes++;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++; if (out_vld !== 1'b0 || out_idx !== '0) $display("FAIL txd_clear: vld %b idx %0d want 0 0", out_vld, out_idx); else passes++;
        fds = 0; t = 0;
        while (out_vld !== 1'b1 && t < 20) begin
            if (frame_done === 1'b1) fds++;
            step(); t++;
        end
        checks++; if (out_vld !== 1'b1 || out_idx !== '0 || pool_0 !== DW'(29)) $display("FAIL txd_restart: vld %b idx %0d pool %0d want 1 0 29", out_vld, out_idx, pool_0); else passes++;
        checks++; if (fds != 0) $display("FAIL txd_fd: got %0d pulses want 0", fds); else passes++;
    endtask

    initial begin
        test_reset();
        run_frame(1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 1'b1, 1'b0);
        run_frame(1'b1, 1'b1, 1'b1);
        test_backpressure();
        test_max();
        test_tx_done();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/l0_pool_reader.md
# l0_pool_reader

Read-side consumer of the layer-0 feature-map RAMs. Walks a W×H map per channel in 2×2 windows (stride 2). Reads four pixels per window from both channel RAMs and emits the per-channel maximum as one pooled pixel over a valid/ready handshake to layer 1. Reading is paced by the upstream write count, so pooling overlaps layer-0 computation within a frame.

## Interface
Parameters:
- W, 28, feature-map width in pixels (even)
- H, 28, feature-map height in pixels (even)
- DW, 18, pixel width
- AW, 10, RAM address width (W*H ≤ 2^AW)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- tx_done  in  1  frame clear; synchronous, highest priority
- wr_cnt  in  AW  pixels written so far this frame by layer 0
- ram_addr  out  AW  shared read address to both channel RAMs
- ram_dout_0  in  DW  channel-0 RAM read data (1-cycle synchronous read)
- ram_dout_1  in  DW  channel-1 RAM read data
- out_vld  out  1  pooled pixel valid
- out_rdy  in  1  downstream accept
- pool_0  out  DW  channel-0 pooled max
- pool_1  out  DW  channel-1 pooled max
- out_idx  out  AW  pooled pixel index, row-major over (W/2)×(H/2)
- frame_done  out  1  one-cycle pulse after the last pooled pixel is accepted

## Operation
- Window (r,c), r∈[0,H/2), c∈[0,W/2). Base address b = 2r·W + 2c. Window order b, b+1, b+W, b+W+1.
- Base register advance on handshake:
  - b += 2 within a row.
  - At c = W/2−1, b += W+2 and the row wraps.
- out_idx increments by 1 per handshake.
- FSM states: WAIT, RD, CAP, OUT, DONE. Reset state is WAIT.
  - WAIT → RD when wr_cnt ≥ b+W+2, i.e. all four pixels have been written. wr_cnt is sampled only in WAIT.
  - RD: 4 cycles, sub-counter k=0..3; ram_addr = window address k. Data for k arrives the next cycle.
    - At the first data cycle, max_n ← ram_dout_n.
    - On later data cycles, max_n ← max(max_n, ram_dout_n).
  - CAP: 1 cycle; compares the fourth datum; → OUT.
  - OUT: out_vld=1, pool_n = max_n.
    - Hold while !out_rdy.
    - On out_vld&&out_rdy: advance position, then go to WAIT.
    - If the last window (idx = (W/2)(H/2)−1) is accepted, go to DONE instead.
  - DONE: frame_done=1 on the entry cycle only. Stay in DONE until tx_done.
- Compare is unsigned, because the data is ReLU output. Equal values are a don't-care (same value).
- tx_done:
  - Forces WAIT and clears b, out_idx, and max regs. out_vld is 0 the next cycle.
  - Beats a simultaneous handshake; that pixel is dropped and not counted.
- No reads are issued outside RD. ram_addr holds its last value otherwise.

## Timing
- Reset values: out_vld=0, pool_0=pool_1=0, out_idx=0, frame_done=0, ram_addr=0, state WAIT.
- Latency: RD entered in cycle t. out_vld is high in cycle t+5 (RD×4, CAP×1).
- Gating: wr_cnt reaching the threshold in cycle t (registered) gives RD in cycle t+1.
- Throughput with out_rdy held high and the frame fully written: one pooled pixel per 7 cycles (WAIT, RD×4, CAP, OUT).
- pool_0, pool_1 and out_idx are stable for the whole time out_vld=1.
- frame_done is high in the cycle after the final handshake, for 1 cycle.
- Asynchronous reset mid-frame returns all outputs to their reset values immediately.

## Test plan
- Reset: assert rst_n=0 mid-RD → all outputs 0 and state WAIT in the same cycle. After release, no reads until wr_cnt ≥ 30.
- Full frame with W=H=28, RAM data = address on both channels, wr_cnt=784, out_rdy=1:
  - idx0 = 29, idx1 = 31, idx13 = 55, idx14 = 85, idx195 = 783.
  - Exactly 196 outputs, then a single frame_done pulse.
- Write gating: wr_cnt=29 held for 20 cycles → ram_addr unchanged, out_vld=0. wr_cnt=30 → RD next cycle, out_vld 5 cycles later with pool = 29.
- Backpressure: out_rdy=0 for 10 cycles in OUT → out_vld, pool_n and out_idx held, no RAM reads. out_rdy=1 → handshake, next base b+2.
- Per-channel max: window ch0 = {5, 9, 18'h3FFFF, 1} and ch1 = {7, 0, 0, 0} → pool_0 = 18'h3FFFF (unsigned), pool_1 = 7.
- tx_done coincident with a handshake at idx 40 → pixel not counted. Next output is idx0 at base 0, and frame_done is not pulsed.
